// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Purpose  : Shared encodings and constant helpers for the UART transmitter:
//            parity-mode encoding, transmitter FSM state encoding, and the
//            baud divisor / baud-counter width computation.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Line-configuration parity selector as seen on the parity_mode port.
  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  // Transmitter frame state.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Clock cycles per bit period (integer division, truncating).
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Bits needed by a counter that runs 0 .. div-1 (never narrower than 1).
  function automatic int cnt_width(input int div);
    if (div <= 2) begin
      return 1;
    end
    return $clog2(div);
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Purpose  : Single-clock FIFO with first-word-fall-through read data.
//            DEPTH must be a power of two (pointers wrap naturally).
//            Push while full and pop while empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok;
  logic             pop_ok;

  // Flags come straight from the registered level, so a pop can never
  // combinationally release a full condition.
  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage array: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push+pop keeps level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_ext.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_ext
// Purpose  : Buffered UART transmitter. Words enter a small FIFO and are sent
//            as start + DATA_BITS (LSB first) + optional parity + 1/2 stop
//            bits. Frames are chained with no idle gap while words remain.
// Config   : UART_TX_PARITY_EN - when defined, parity_mode 01/10 adds an
//            even/odd parity bit; when undefined parity_mode is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int            BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int            CW       = cnt_width(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam int            BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = 1;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [DATA_BITS-1:0]  shift_q;
  logic [BW-1:0]         bit_q;
  logic                  stop2_q;
  logic                  stop_idx_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  bit_end;
  logic                  frame_end;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_rdata;

`ifdef UART_TX_PARITY_EN
  logic                  par_en_q;
  logic                  par_bit_q;
`else
  logic                  unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  assign fifo_push = in_valid && !fifo_full;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Bit-period timing and the pop decision (idle pickup or chained frame).
  always_comb begin
    bit_end   = (state_q != IDLE) && (cnt_q == CNT_LAST);
    cnt_d     = (state_q == IDLE || bit_end) ? '0 : cnt_q + CNT_ONE;
    frame_end = (state_q == STOP) && bit_end && (!stop2_q || stop_idx_q);
    fifo_pop  = !fifo_empty && ((state_q == IDLE) || frame_end);
  end

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q    <= STOP;
                tx_q       <= 1'b1;
                stop_idx_q <= 1'b0;
              end
`else
              state_q    <= STOP;
              tx_q       <= 1'b1;
              stop_idx_q <= 1'b0;
`endif
            end else begin
              bit_q   <= bit_q + BIT_ONE;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q    <= STOP;
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
          end
        end
        STOP: begin
          if (frame_end) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
          end else if (bit_end) begin
            stop_idx_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
      endcase
      // A pop overrides the IDLE fallback above so the next start bit
      // follows the last stop bit with no gap.
      if (fifo_pop) begin
        state_q <= START;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
        shift_q <= fifo_rdata;
        stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
        par_en_q  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        par_bit_q <= (^fifo_rdata) ^ (parity_mode == PAR_ODD);
`endif
      end
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign in_ready = !fifo_full;

endmodule : uart_tx_ext
`default_nettype wire

// File: tb/tb_uart_tx_ext.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ext
// Purpose  : Self-checking bench for uart_tx_ext. Expected frames are built
//            from the stimulus and queued; a line monitor slices tx into bit
//            periods and queues what it saw for the scenario tasks to compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ext;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = 10;
  localparam int DW       = 8;
  localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop2 = 1'b0;
  logic          tx;
  logic          busy;
  logic          tx_done;
  logic [2:0]    fifo_level;

  typedef struct {
    logic [11:0] bits;
    int          len;
  } exp_t;

  typedef struct {
    logic [11:0] bits;
    bit          stable;
    int          start;
    int          done_k;
    int          done_cnt;
  } rx_t;

  exp_t exp_q[$];
  int   len_q[$];
  rx_t  rx_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  uart_tx_ext #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .DATA_BITS  (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done),
    .fifo_level  (fifo_level)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference frame: start 0, data LSB first, optional parity, stop bit(s).
  function automatic exp_t mk(input logic [7:0] d, input logic [1:0] pm, input logic s2);
    exp_t e;
    int   n;
    e.bits    = '1;
    e.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
    n = 9;
    if (PAR_EN && pm == 2'b01) begin
      e.bits[n] = ^d;
      n++;
    end else if (PAR_EN && pm == 2'b10) begin
      e.bits[n] = ~(^d);
      n++;
    end
    e.bits[n] = 1'b1;
    n++;
    if (s2) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.len = n;
    return e;
  endfunction

  // Line monitor: k counts negedges from the first low sample of a frame.
  initial begin
    bit          m_act = 1'b0;
    int          m_k = 0;
    int          m_len = 10;
    logic [11:0] m_bits = '1;
    bit          m_stable = 1'b1;
    int          m_start = 0;
    int          m_done_k = -1;
    int          m_done_cnt = 0;
    rx_t         r;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_act = 1'b0;
      end else begin
        if (m_act) begin
          if (tx_done === 1'b1) begin
            if (m_done_k < 0) m_done_k = m_k;
            m_done_cnt++;
          end
          if (m_k == m_len * DIV) begin
            r.bits     = m_bits;
            r.stable   = m_stable;
            r.start    = m_start;
            r.done_k   = m_done_k;
            r.done_cnt = m_done_cnt;
            rx_q.push_back(r);
            m_act = 1'b0;
          end else begin
            if (m_k % DIV == 0) m_bits[m_k / DIV] = tx;
            else if (tx !== m_bits[m_k / DIV]) m_stable = 1'b0;
            m_k++;
          end
        end
        if (!m_act && tx === 1'b0) begin
          m_act = 1'b1;
          if (len_q.size() > 0) m_len = len_q.pop_front();
          else m_len = 10;
          m_bits     = '1;
          m_bits[0]  = 1'b0;
          m_stable   = 1'b1;
          m_done_k   = -1;
          m_done_cnt = 0;
          m_start    = cyc;
          m_k        = 1;
        end
      end
    end
  end

  // Offer one word for a single edge; called and returning at a negedge.
  task automatic drive_word(input logic [7:0] d, input logic [1:0] pm, input logic s2);
    exp_t e;
    e = mk(d, pm, s2);
    exp_q.push_back(e);
    len_q.push_back(e.len);
    in_data = d; parity_mode = pm; stop2 = s2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", tx_done); end
    n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t e; rx_t r;
    drive_word(8'h55, 2'b00, 1'b0);
    n_vec++; if (tx !== 1'b1 || fifo_level !== 3'd1) begin
      n_err++; $display("FAIL basic_write_edge: got tx=%b level=%0d want tx=1 level=1", tx, fifo_level); end
    @(negedge clk);
    n_vec++; if (tx !== 1'b0 || busy !== 1'b1 || fifo_level !== 3'd0) begin
      n_err++; $display("FAIL basic_latency: got tx=%b busy=%b level=%0d want 0 1 0", tx, busy, fifo_level); end
    parity_mode = 2'b01; stop2 = 1'b1;
    for (int i = 0; i < 300 && rx_q.size() < 1; i++) @(negedge clk);
    n_vec++;
    if (rx_q.size() < 1) begin
      n_err++; $display("FAIL basic_timeout: got 0 frames want 1");
    end else begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      if (r.bits !== e.bits || !r.stable) begin
        n_err++; $display("FAIL basic_frame: got %b stable=%0d want %b", r.bits, r.stable, e.bits); end
      n_vec++; if (r.done_k != 100 || r.done_cnt != 1) begin
        n_err++; $display("FAIL basic_done: got k=%0d cnt=%0d want k=100 cnt=1", r.done_k, r.done_cnt); end
      @(negedge clk);
      n_vec++; if (tx_done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
        n_err++; $display("FAIL basic_idle: got done=%b busy=%b tx=%b want 0 0 1", tx_done, busy, tx); end
    end
    parity_mode = 2'b00; stop2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    exp_t e; rx_t r;
    logic [1:0] modes [2];
    logic       pbit  [2];
    modes = '{2'b01, 2'b10};
    pbit  = '{1'b1, 1'b0};
    for (int m = 0; m < 2; m++) begin
      drive_word(8'h07, modes[m], 1'b0);
      for (int i = 0; i < 300 && rx_q.size() < 1; i++) @(negedge clk);
      n_vec++;
      if (rx_q.size() < 1) begin
        n_err++; $display("FAIL parity_timeout: mode=%b got 0 frames want 1", modes[m]);
      end else begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        if (r.bits[9] !== pbit[m]) begin
          n_err++; $display("FAIL parity_bit: mode=%b got %b want %b", modes[m], r.bits[9], pbit[m]); end
        n_vec++; if (r.bits !== e.bits || !r.stable) begin
          n_err++; $display("FAIL parity_frame: got %b stable=%0d want %b", r.bits, r.stable, e.bits); end
        n_vec++; if (r.done_k != 110 || r.done_cnt != 1) begin
          n_err++; $display("FAIL parity_done: got k=%0d cnt=%0d want k=110 cnt=1", r.done_k, r.done_cnt); end
      end
      repeat (3) @(negedge clk);
    end
  endtask
`else
  task automatic test_parity_ignored();
    exp_t e; rx_t r;
    drive_word(8'hA5, 2'b01, 1'b0);
    for (int i = 0; i < 300 && rx_q.size() < 1; i++) @(negedge clk);
    n_vec++;
    if (rx_q.size() < 1) begin
      n_err++; $display("FAIL noparity_timeout: got 0 frames want 1");
    end else begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      if (r.bits !== e.bits || !r.stable) begin
        n_err++; $display("FAIL noparity_frame: got %b stable=%0d want %b", r.bits, r.stable, e.bits); end
      n_vec++; if (r.done_k != 100 || r.done_cnt != 1) begin
        n_err++; $display("FAIL noparity_done: got k=%0d cnt=%0d want k=100 cnt=1", r.done_k, r.done_cnt); end
    end
    parity_mode = 2'b00;
    repeat (3) @(negedge clk);
  endtask
`endif

  task automatic test_stop2();
    exp_t e; rx_t r;
    drive_word(8'hFF, 2'b00, 1'b1);
    @(negedge clk);
    stop2 = 1'b0; parity_mode = 2'b10;
    for (int i = 0; i < 300 && rx_q.size() < 1; i++) @(negedge clk);
    n_vec++;
    if (rx_q.size() < 1) begin
      n_err++; $display("FAIL stop2_timeout: got 0 frames want 1");
    end else begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      if (r.bits !== e.bits || !r.stable) begin
        n_err++; $display("FAIL stop2_frame: got %b stable=%0d want %b", r.bits, r.stable, e.bits); end
      n_vec++; if (r.done_k != 110 || r.done_cnt != 1) begin
        n_err++; $display("FAIL stop2_done: got k=%0d cnt=%0d want k=110 cnt=1", r.done_k, r.done_cnt); end
    end
    parity_mode = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e; rx_t r;
    logic [7:0] words [6];
    int acc_edge [6];
    int acc = 0;
    int peak = 0;
    int prev_start = 0;
    words = '{8'h11, 8'h22, 8'hA3, 8'h4C, 8'hF0, 8'h5A};
    acc_edge = '{-1, -1, -1, -1, -1, -1};
    parity_mode = 2'b00; stop2 = 1'b0;
    in_data = words[0]; in_valid = 1'b1;
    for (int t = 0; t < 300 && acc < 6; t++) begin
      if (in_ready === 1'b1) begin
        e = mk(words[acc], 2'b00, 1'b0);
        exp_q.push_back(e); len_q.push_back(e.len);
        acc_edge[acc] = t;
        acc++;
      end
      @(negedge clk);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (acc < 6) in_data = words[acc];
    end
    in_valid = 1'b0;
    n_vec++; if (acc != 6 || acc_edge[4] != 4) begin
      n_err++; $display("FAIL b2b_accept: got acc=%0d edge4=%0d want 6 and 4", acc, acc_edge[4]); end
    n_vec++; if (acc_edge[5] != 102) begin
      n_err++; $display("FAIL b2b_sixth_held: got edge %0d want 102", acc_edge[5]); end
    n_vec++; if (peak != 4) begin
      n_err++; $display("FAIL b2b_peak_level: got %0d want 4", peak); end
    for (int i = 0; i < 900 && rx_q.size() < 6; i++) @(negedge clk);
    n_vec++;
    if (rx_q.size() < 6) begin
      n_err++; $display("FAIL b2b_timeout: got %0d frames want 6", rx_q.size());
    end else begin
      for (int f = 0; f < 6; f++) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        n_vec++; if (r.bits !== e.bits || !r.stable) begin
          n_err++; $display("FAIL b2b_frame%0d: got %b stable=%0d want %b", f, r.bits, r.stable, e.bits); end
        n_vec++; if (r.done_k != 100 || r.done_cnt != 1) begin
          n_err++; $display("FAIL b2b_done%0d: got k=%0d cnt=%0d want k=100 cnt=1", f, r.done_k, r.done_cnt); end
        if (f > 0) begin
          n_vec++; if (r.start - prev_start != 100) begin
            n_err++; $display("FAIL b2b_gap%0d: got spacing %0d want 100", f, r.start - prev_start); end
        end
        prev_start = r.start;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int done_seen = 0;
    int low_seen = 0;
    drive_word(8'h3C, 2'b00, 1'b0);
    drive_word(8'h81, 2'b00, 1'b0);
    // now at k=0 of frame 1; data bit 3 spans k=40..49
    repeat (42) @(negedge clk);
    n_vec++; if (fifo_level !== 3'd1 || busy !== 1'b1) begin
      n_err++; $display("FAIL midreset_pre: got level=%0d busy=%b want 1 1", fifo_level, busy); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL midreset_tx: got %b want 1", tx); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL midreset_level: got %0d want 0", fifo_level); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
    n_vec++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b want 0", tx_done); end
    rst = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_seen++;
      if (tx !== 1'b1) low_seen++;
    end
    n_vec++; if (done_seen != 0 || low_seen != 0) begin
      n_err++; $display("FAIL midreset_quiet: got done=%0d low=%0d want 0 0", done_seen, low_seen); end
    n_vec++; if (rx_q.size() != 0) begin
      n_err++; $display("FAIL midreset_frames: got %0d want 0", rx_q.size()); end
    exp_q.delete(); len_q.delete(); rx_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef UART_TX_PARITY_EN
    test_parity();
`else
    test_parity_ignored();
`endif
    test_stop2();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish by 500us want finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_uart_tx_ext
`default_nettype wire
